// File: rtl/bus_if_split_pkg.sv
// Shared bus package.
// Holds the command/response encodings and the address/data widths that
// every block speaking the Bus_if protocol agrees on.
package Bus;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    // Master command encoding; IDLE means no request this cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } Bus_cmd;

    // Slave response encoding; NULL means no response this cycle,
    // DVA means data valid / write acknowledged.
    typedef enum logic [1:0] {
        NULL = 2'd0,
        DVA  = 2'd1,
        ERR  = 2'd3
    } Bus_resp;

endpackage

// File: rtl/Bus_if.sv
// Bus interface bundle.
// Master side drives command, address, write data, byte enables, response
// accept and the slave reset. Slave side drives command/data accept and the
// response with its read data.
//   master modport : used by a block that issues commands downstream
//   slave modport  : used by a block that receives commands from upstream
interface Bus_if;

    Bus::Bus_cmd                 MCmd;
    logic [Bus::ADDR_WIDTH-1:0]  MAddr;
    logic [Bus::DATA_WIDTH-1:0]  MData;
    logic                        MDataValid;
    logic [Bus::BE_WIDTH-1:0]    MByteEn;
    logic                        MRespAccept;
    logic                        MReset_n;

    logic                        SCmdAccept;
    logic                        SDataAccept;
    Bus::Bus_resp                SResp;
    logic [Bus::DATA_WIDTH-1:0]  SData;

    modport master (
        output MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept, MReset_n,
        input  SCmdAccept, SDataAccept, SResp, SData
    );

    modport slave (
        input  MCmd, MAddr, MData, MDataValid, MByteEn, MRespAccept, MReset_n,
        output SCmdAccept, SDataAccept, SResp, SData
    );

endinterface

// File: rtl/bus_resp_order_fifo.sv
// Response-order FIFO.
// Remembers, for every accepted command, which slave port it went to, so
// responses can be handed back to the master in command order.
//   Clk, Reset : clock and asynchronous active-high reset
//   push, din  : write one entry (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   dout       : current head entry, meaningful only when !empty
//   empty/full : registered status flags
module bus_resp_order_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // Next-state for storage, pointers and count. The flags are derived
    // from the next count and registered, so a pop while full only frees
    // the slot for a push in the following cycle. Pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = empty_q;
    assign full  = full_q;

    a_no_pop_empty: assert property (@(posedge Clk) disable iff (Reset) !(pop && empty_q));
    a_count_bound:  assert property (@(posedge Clk) disable iff (Reset) count_q <= CW'(DEPTH));

endmodule

// File: rtl/bus_if_split.sv
// One-to-two bus demultiplexer.
// Routes each command from the upstream master to out_1 when its address
// matches ADDR_BASE_1 under ADDR_MASK, otherwise to out_0. Responses go back
// upstream strictly in command order, tracked by a small selector FIFO.
//   Clk, Reset : clock and asynchronous active-high reset
//   in         : upstream master side (slave modport)
//   out_0      : default address region (master modport)
//   out_1      : region decoded by ADDR_BASE_1 (master modport)
module bus_if_split #(
    parameter int                         NUM_IN_FLIGHT = 4,
    parameter logic [Bus::ADDR_WIDTH-1:0] ADDR_MASK     = 32'hF000_0000,
    parameter logic [Bus::ADDR_WIDTH-1:0] ADDR_BASE_1   = 32'h8000_0000
) (
    input logic   Clk,
    input logic   Reset,
    Bus_if.slave  in,
    Bus_if.master out_0,
    Bus_if.master out_1
);

    function automatic logic addr_decode(input logic [Bus::ADDR_WIDTH-1:0] addr);
        return (addr & ADDR_MASK) == ADDR_BASE_1;
    endfunction

    logic         sel;
    logic         hd;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         cmd_valid;
    logic         sel_accept;
    Bus::Bus_resp hd_resp;

    // Request and response steering. Every output starts at its idle value;
    // only the selected port carries the command, and only the port at the
    // FIFO head may see MRespAccept, which keeps the other slave holding its
    // response until its turn comes.
    always_comb begin
        sel        = addr_decode(in.MAddr);
        cmd_valid  = !Reset && !full && (in.MCmd != Bus::IDLE);
        sel_accept = sel ? out_1.SCmdAccept : out_0.SCmdAccept;

        out_0.MCmd        = Bus::IDLE;
        out_0.MAddr       = '0;
        out_0.MData       = '0;
        out_0.MDataValid  = 1'b0;
        out_0.MByteEn     = '0;
        out_0.MRespAccept = 1'b0;
        out_1.MCmd        = Bus::IDLE;
        out_1.MAddr       = '0;
        out_1.MData       = '0;
        out_1.MDataValid  = 1'b0;
        out_1.MByteEn     = '0;
        out_1.MRespAccept = 1'b0;
        in.SCmdAccept     = 1'b0;
        in.SDataAccept    = 1'b0;
        in.SResp          = Bus::NULL;
        in.SData          = '0;
        hd_resp           = Bus::NULL;

        if (cmd_valid) begin
            if (sel) begin
                out_1.MCmd       = in.MCmd;
                out_1.MAddr      = in.MAddr;
                out_1.MData      = in.MData;
                out_1.MDataValid = in.MDataValid;
                out_1.MByteEn    = in.MByteEn;
            end else begin
                out_0.MCmd       = in.MCmd;
                out_0.MAddr      = in.MAddr;
                out_0.MData      = in.MData;
                out_0.MDataValid = in.MDataValid;
                out_0.MByteEn    = in.MByteEn;
            end
        end

        if (!Reset && !full) begin
            in.SCmdAccept  = sel_accept;
            in.SDataAccept = sel_accept;
        end

        if (!empty) begin
            if (hd) begin
                hd_resp           = out_1.SResp;
                in.SData          = out_1.SData;
                out_1.MRespAccept = in.MRespAccept;
            end else begin
                hd_resp           = out_0.SResp;
                in.SData          = out_0.SData;
                out_0.MRespAccept = in.MRespAccept;
            end
            in.SResp = hd_resp;
        end

        push = cmd_valid && sel_accept;
        pop  = !empty && (hd_resp != Bus::NULL) && in.MRespAccept;
    end

    assign out_0.MReset_n = !Reset;
    assign out_1.MReset_n = !Reset;

    bus_resp_order_fifo #(
        .WIDTH (1),
        .DEPTH (NUM_IN_FLIGHT)
    ) u_order_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .din   (sel),
        .dout  (hd),
        .empty (empty),
        .full  (full)
    );

    a_one_port_active: assert property (@(posedge Clk) disable iff (Reset)
        !((out_0.MCmd != Bus::IDLE) && (out_1.MCmd != Bus::IDLE)));

endmodule

// File: tb/tb_bus_if_split.sv
// Directed testbench for bus_if_split.
// Drives the upstream master and both slave ports by hand, cycle by cycle,
// and compares the demultiplexer outputs against hand-computed values.
module tb_bus_if_split;

    logic Clk;
    logic Reset;
    int   n_vec;
    int   n_err;

    Bus_if in_if ();
    Bus_if o0_if ();
    Bus_if o1_if ();

    bus_if_split #(
        .NUM_IN_FLIGHT (4),
        .ADDR_MASK     (32'hF000_0000),
        .ADDR_BASE_1   (32'h8000_0000)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .in    (in_if),
        .out_0 (o0_if),
        .out_1 (o1_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_idle();
        in_if.MCmd        = Bus::IDLE;
        in_if.MAddr       = '0;
        in_if.MData       = '0;
        in_if.MDataValid  = 1'b0;
        in_if.MByteEn     = '0;
        in_if.MRespAccept = 1'b1;
        in_if.MReset_n    = 1'b1;
        o0_if.SCmdAccept  = 1'b0;
        o0_if.SDataAccept = 1'b0;
        o0_if.SResp       = Bus::NULL;
        o0_if.SData       = '0;
        o1_if.SCmdAccept  = 1'b0;
        o1_if.SDataAccept = 1'b0;
        o1_if.SResp       = Bus::NULL;
        o1_if.SData       = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive_idle();
        in_if.MCmd  = Bus::READ;
        in_if.MAddr = 32'h0000_0010;
        o0_if.SCmdAccept = 1'b1;
        #12;
        n_vec++;
        if (o0_if.MReset_n !== 1'b0 || o1_if.MReset_n !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_mreset_n: got %0b/%0b want 0/0", o0_if.MReset_n, o1_if.MReset_n);
        end
        n_vec++;
        if (o0_if.MCmd !== Bus::IDLE || o1_if.MCmd !== Bus::IDLE) begin
            n_err++;
            $display("[TB] FAIL reset_mcmd: got %0d/%0d want IDLE", o0_if.MCmd, o1_if.MCmd);
        end
        n_vec++;
        if (in_if.SCmdAccept !== 1'b0 || in_if.SDataAccept !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_accept: got %0b/%0b want 0/0", in_if.SCmdAccept, in_if.SDataAccept);
        end
        n_vec++;
        if (in_if.SResp !== Bus::NULL || in_if.SData !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL reset_resp: got %0d/%h want NULL/0", in_if.SResp, in_if.SData);
        end
        drive_idle();
        cyc();
        Reset = 1'b0;
        #1;
        n_vec++;
        if (o0_if.MReset_n !== 1'b1 || o1_if.MReset_n !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL release_mreset_n: got %0b/%0b want 1/1", o0_if.MReset_n, o1_if.MReset_n);
        end
    endtask

    task automatic test_single_read();
        cyc();
        in_if.MCmd = Bus::READ;
        in_if.MAddr = 32'h0000_0010;
        o0_if.SCmdAccept = 1'b1;
        #1;
        n_vec++;
        if (in_if.SCmdAccept !== 1'b1 || o0_if.MCmd !== Bus::READ || o0_if.MAddr !== 32'h0000_0010) begin
            n_err++;
            $display("[TB] FAIL single_cmd: acc=%0b cmd=%0d addr=%h want 1/READ/00000010",
                     in_if.SCmdAccept, o0_if.MCmd, o0_if.MAddr);
        end
        for (int c = 1; c <= 2; c++) begin
            cyc();
            in_if.MCmd = Bus::IDLE;
            o0_if.SCmdAccept = 1'b0;
            #1;
            n_vec++;
            if (in_if.SResp !== Bus::NULL || o1_if.MCmd !== Bus::IDLE) begin
                n_err++;
                $display("[TB] FAIL single_wait%0d: resp=%0d o1cmd=%0d want NULL/IDLE", c, in_if.SResp, o1_if.MCmd);
            end
        end
        cyc();
        o0_if.SResp = Bus::DVA;
        o0_if.SData = 32'hDEAD_BEEF;
        #1;
        n_vec++;
        if (in_if.SResp !== Bus::DVA || in_if.SData !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("[TB] FAIL single_resp: got %0d/%h want DVA/deadbeef", in_if.SResp, in_if.SData);
        end
        n_vec++;
        if (o0_if.MRespAccept !== 1'b1 || o1_if.MRespAccept !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_racc: got %0b/%0b want 1/0", o0_if.MRespAccept, o1_if.MRespAccept);
        end
        cyc();
        o0_if.SResp = Bus::NULL;
        o0_if.SData = '0;
        #1;
        n_vec++;
        if (in_if.SResp !== Bus::NULL || o0_if.MRespAccept !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL single_drained: resp=%0d racc=%0b want NULL/0", in_if.SResp, o0_if.MRespAccept);
        end
    endtask

    task automatic test_ordering();
        cyc();
        in_if.MCmd = Bus::READ;
        in_if.MAddr = 32'h8000_0004;
        o1_if.SCmdAccept = 1'b1;
        #1;
        n_vec++;
        if (o1_if.MCmd !== Bus::READ || o0_if.MCmd !== Bus::IDLE || in_if.SCmdAccept !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL order_cmd1: o1=%0d o0=%0d acc=%0b want READ/IDLE/1",
                     o1_if.MCmd, o0_if.MCmd, in_if.SCmdAccept);
        end
        cyc();
        in_if.MAddr = 32'h0000_0008;
        o1_if.SCmdAccept = 1'b0;
        o0_if.SCmdAccept = 1'b1;
        #1;
        n_vec++;
        if (o0_if.MCmd !== Bus::READ || o1_if.MCmd !== Bus::IDLE || in_if.SCmdAccept !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL order_cmd2: o0=%0d o1=%0d acc=%0b want READ/IDLE/1",
                     o0_if.MCmd, o1_if.MCmd, in_if.SCmdAccept);
        end
        cyc();
        in_if.MCmd = Bus::IDLE;
        in_if.MAddr = '0;
        o0_if.SCmdAccept = 1'b0;
        o0_if.SResp = Bus::DVA;
        o0_if.SData = 32'h0000_0A0A;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (o0_if.MRespAccept !== 1'b0 || in_if.SResp !== Bus::NULL) begin
                n_err++;
                $display("[TB] FAIL order_hold%0d: o0racc=%0b resp=%0d want 0/NULL", c, o0_if.MRespAccept, in_if.SResp);
            end
            cyc();
        end
        o1_if.SResp = Bus::DVA;
        o1_if.SData = 32'h1111_1111;
        #1;
        n_vec++;
        if (in_if.SData !== 32'h1111_1111 || o1_if.MRespAccept !== 1'b1 || o0_if.MRespAccept !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL order_first: data=%h racc1=%0b racc0=%0b want 11111111/1/0",
                     in_if.SData, o1_if.MRespAccept, o0_if.MRespAccept);
        end
        cyc();
        o1_if.SResp = Bus::NULL;
        o1_if.SData = '0;
        #1;
        n_vec++;
        if (in_if.SData !== 32'h0000_0A0A || in_if.SResp !== Bus::DVA || o0_if.MRespAccept !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL order_second: data=%h resp=%0d racc0=%0b want 00000a0a/DVA/1",
                     in_if.SData, in_if.SResp, o0_if.MRespAccept);
        end
        cyc();
        o0_if.SResp = Bus::NULL;
        o0_if.SData = '0;
        #1;
        n_vec++;
        if (in_if.SResp !== Bus::NULL) begin
            n_err++;
            $display("[TB] FAIL order_drained: resp=%0d want NULL", in_if.SResp);
        end
    endtask

    task automatic test_full();
        in_if.MRespAccept = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            in_if.MCmd = Bus::READ;
            in_if.MAddr = 32'h0000_0100 + 32'(4 * i);
            o0_if.SCmdAccept = 1'b1;
            #1;
            n_vec++;
            if (in_if.SCmdAccept !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL full_fill%0d: acc=%0b want 1", i, in_if.SCmdAccept);
            end
        end
        cyc();
        in_if.MAddr = 32'h0000_0110;
        #1;
        n_vec++;
        if (in_if.SCmdAccept !== 1'b0 || o0_if.MCmd !== Bus::IDLE) begin
            n_err++;
            $display("[TB] FAIL full_stall: acc=%0b o0cmd=%0d want 0/IDLE", in_if.SCmdAccept, o0_if.MCmd);
        end
        cyc();
        o0_if.SResp = Bus::DVA;
        o0_if.SData = 32'h0000_00A0;
        in_if.MRespAccept = 1'b1;
        #1;
        n_vec++;
        if (in_if.SCmdAccept !== 1'b0 || in_if.SData !== 32'h0000_00A0) begin
            n_err++;
            $display("[TB] FAIL full_popcycle: acc=%0b data=%h want 0/000000a0", in_if.SCmdAccept, in_if.SData);
        end
        cyc();
        o0_if.SResp = Bus::NULL;
        o0_if.SData = '0;
        #1;
        n_vec++;
        if (in_if.SCmdAccept !== 1'b1 || o0_if.MCmd !== Bus::READ || o0_if.MAddr !== 32'h0000_0110) begin
            n_err++;
            $display("[TB] FAIL full_resume: acc=%0b cmd=%0d addr=%h want 1/READ/00000110",
                     in_if.SCmdAccept, o0_if.MCmd, o0_if.MAddr);
        end
        cyc();
        in_if.MCmd = Bus::IDLE;
        in_if.MAddr = '0;
        o0_if.SCmdAccept = 1'b0;
        for (int j = 0; j < 4; j++) begin
            o0_if.SResp = Bus::DVA;
            o0_if.SData = 32'h0000_00B0 + 32'(j);
            #1;
            n_vec++;
            if (in_if.SResp !== Bus::DVA || in_if.SData !== 32'h0000_00B0 + 32'(j)) begin
                n_err++;
                $display("[TB] FAIL full_drain%0d: resp=%0d data=%h want DVA/%h",
                         j, in_if.SResp, in_if.SData, 32'h0000_00B0 + 32'(j));
            end
            cyc();
        end
        o0_if.SResp = Bus::NULL;
        o0_if.SData = '0;
        #1;
        n_vec++;
        if (in_if.SResp !== Bus::NULL || o0_if.MRespAccept !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL full_empty: resp=%0d racc=%0b want NULL/0", in_if.SResp, o0_if.MRespAccept);
        end
    endtask

    task automatic test_write_stall();
        cyc();
        in_if.MCmd = Bus::WRITE;
        in_if.MAddr = 32'h8000_0020;
        in_if.MData = 32'h1234_5678;
        in_if.MDataValid = 1'b1;
        in_if.MByteEn = 4'hF;
        o1_if.SCmdAccept = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if (in_if.SCmdAccept !== 1'b0 || in_if.SDataAccept !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL wr_stall%0d: acc=%0b dacc=%0b want 0/0", c, in_if.SCmdAccept, in_if.SDataAccept);
            end
            n_vec++;
            if (o1_if.MCmd !== Bus::WRITE || o1_if.MData !== 32'h1234_5678 ||
                o1_if.MDataValid !== 1'b1 || o1_if.MByteEn !== 4'hF) begin
                n_err++;
                $display("[TB] FAIL wr_fwd%0d: cmd=%0d data=%h dv=%0b be=%h want WRITE/12345678/1/f",
                         c, o1_if.MCmd, o1_if.MData, o1_if.MDataValid, o1_if.MByteEn);
            end
            cyc();
        end
        o1_if.SCmdAccept = 1'b1;
        #1;
        n_vec++;
        if (in_if.SCmdAccept !== 1'b1 || in_if.SDataAccept !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL wr_accept: acc=%0b dacc=%0b want 1/1", in_if.SCmdAccept, in_if.SDataAccept);
        end
        cyc();
        drive_idle();
        o1_if.SResp = Bus::DVA;
        #1;
        n_vec++;
        if (in_if.SResp !== Bus::DVA || o1_if.MRespAccept !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL wr_dva: resp=%0d racc=%0b want DVA/1", in_if.SResp, o1_if.MRespAccept);
        end
        cyc();
        #1;
        n_vec++;
        if (in_if.SResp !== Bus::NULL || o1_if.MRespAccept !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL wr_empty: resp=%0d racc=%0b want NULL/0", in_if.SResp, o1_if.MRespAccept);
        end
        o1_if.SResp = Bus::NULL;
    endtask

    task automatic test_back_to_back();
        cyc();
        in_if.MCmd = Bus::READ;
        in_if.MAddr = 32'h0000_0040;
        o0_if.SCmdAccept = 1'b1;
        #1;
        n_vec++;
        if (in_if.SCmdAccept !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL b2b_first: acc=%0b want 1", in_if.SCmdAccept);
        end
        cyc();
        in_if.MAddr = 32'h8000_0040;
        o0_if.SCmdAccept = 1'b0;
        o1_if.SCmdAccept = 1'b1;
        o0_if.SResp = Bus::DVA;
        o0_if.SData = 32'h0000_0055;
        #1;
        n_vec++;
        if (in_if.SCmdAccept !== 1'b1 || in_if.SData !== 32'h0000_0055 || o0_if.MRespAccept !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL b2b_same_cycle: acc=%0b data=%h racc0=%0b want 1/00000055/1",
                     in_if.SCmdAccept, in_if.SData, o0_if.MRespAccept);
        end
        cyc();
        in_if.MCmd = Bus::IDLE;
        in_if.MAddr = '0;
        o1_if.SCmdAccept = 1'b0;
        o0_if.SResp = Bus::NULL;
        o0_if.SData = '0;
        o1_if.SResp = Bus::DVA;
        o1_if.SData = 32'h0000_0066;
        #1;
        n_vec++;
        if (in_if.SData !== 32'h0000_0066 || o1_if.MRespAccept !== 1'b1 || o0_if.MRespAccept !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL b2b_new_head: data=%h racc1=%0b racc0=%0b want 00000066/1/0",
                     in_if.SData, o1_if.MRespAccept, o0_if.MRespAccept);
        end
        cyc();
        #1;
        n_vec++;
        if (in_if.SResp !== Bus::NULL) begin
            n_err++;
            $display("[TB] FAIL b2b_count_one: resp=%0d want NULL", in_if.SResp);
        end
        o1_if.SResp = Bus::NULL;
        o1_if.SData = '0;
    endtask

    task automatic test_reset_mid();
        cyc();
        in_if.MCmd = Bus::READ;
        in_if.MAddr = 32'h0000_0000;
        o0_if.SCmdAccept = 1'b1;
        cyc();
        in_if.MAddr = 32'h8000_0000;
        o0_if.SCmdAccept = 1'b0;
        o1_if.SCmdAccept = 1'b1;
        cyc();
        drive_idle();
        Reset = 1'b1;
        o0_if.SResp = Bus::DVA;
        o1_if.SResp = Bus::DVA;
        o0_if.SData = 32'h0BAD_0000;
        o1_if.SData = 32'h0BAD_0001;
        #1;
        n_vec++;
        if (in_if.SResp !== Bus::NULL || o0_if.MRespAccept !== 1'b0 || o1_if.MRespAccept !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rstmid_resp: resp=%0d racc=%0b/%0b want NULL/0/0",
                     in_if.SResp, o0_if.MRespAccept, o1_if.MRespAccept);
        end
        n_vec++;
        if (o0_if.MReset_n !== 1'b0 || o1_if.MReset_n !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rstmid_mreset_n: got %0b/%0b want 0/0", o0_if.MReset_n, o1_if.MReset_n);
        end
        cyc();
        Reset = 1'b0;
        #1;
        n_vec++;
        if (in_if.SResp !== Bus::NULL || in_if.SData !== 32'h0 ||
            o0_if.MRespAccept !== 1'b0 || o1_if.MRespAccept !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL rstmid_late: resp=%0d data=%h racc=%0b/%0b want NULL/0/0/0",
                     in_if.SResp, in_if.SData, o0_if.MRespAccept, o1_if.MRespAccept);
        end
        drive_idle();
        cyc();
        in_if.MCmd = Bus::READ;
        in_if.MAddr = 32'h8000_0100;
        o1_if.SCmdAccept = 1'b1;
        #1;
        n_vec++;
        if (in_if.SCmdAccept !== 1'b1 || o1_if.MCmd !== Bus::READ || o1_if.MReset_n !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL rstmid_resume_cmd: acc=%0b cmd=%0d rn=%0b want 1/READ/1",
                     in_if.SCmdAccept, o1_if.MCmd, o1_if.MReset_n);
        end
        cyc();
        drive_idle();
        o1_if.SResp = Bus::DVA;
        o1_if.SData = 32'h0000_0077;
        #1;
        n_vec++;
        if (in_if.SResp !== Bus::DVA || in_if.SData !== 32'h0000_0077) begin
            n_err++;
            $display("[TB] FAIL rstmid_resume_resp: resp=%0d data=%h want DVA/00000077", in_if.SResp, in_if.SData);
        end
        cyc();
        drive_idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_read();
        test_ordering();
        test_full();
        test_write_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
